// File: rtl/fcims_pkg.sv
// Shared types and encodings for the inventory transaction controller.
package fcims_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_CHECK,
    ST_RESP
  } state_t;

  localparam logic [2:0] RSP_OK       = 3'd0;
  localparam logic [2:0] RSP_NO_STOCK = 3'd1;
  localparam logic [2:0] RSP_NO_FUNDS = 3'd2;
  localparam logic [2:0] RSP_OVERFLOW = 3'd3;
  localparam logic [2:0] RSP_BAD_ITEM = 3'd4;

  localparam logic OP_BUY  = 1'b0;
  localparam logic OP_SELL = 1'b1;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle, LSB first.
// Operands are captured on start. done is high during the last of A_W
// work cycles; product is final from the following cycle on.
module seq_multiplier #(
  parameter int unsigned A_W = 4,
  parameter int unsigned B_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int unsigned P_W    = A_W + B_W;
  localparam int unsigned STEP_W = $clog2(A_W + 1);

  logic [A_W-1:0]    a_sh;
  logic [P_W-1:0]    b_sh;
  logic [STEP_W-1:0] steps;
  logic              busy;

  assign done = busy && (steps == STEP_W'(1));

  // Operand capture and one accumulate/shift step per cycle while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      product <= '0;
      steps   <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      a_sh    <= a;
      b_sh    <= {{A_W{1'b0}}, b};
      product <= '0;
      steps   <= STEP_W'(A_W);
      busy    <= 1'b1;
    end else if (busy) begin
      if (a_sh[0]) product <= product + b_sh;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh << 1;
      steps <= steps - STEP_W'(1);
      if (steps == STEP_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/inventory_txn_ctrl.sv
// Inventory transaction controller: per-item stock counts, a funds register,
// and a buy/sell FSM (IDLE -> MUL -> CHECK -> RESP).
// Optional low-stock mask output is enabled with `FCIMS_LOW_STOCK_EN.
module inventory_txn_ctrl
  import fcims_pkg::*;
#(
  parameter  int unsigned NUM_ITEMS  = 4,
  parameter  int unsigned CNT_W      = 4,
  parameter  int unsigned PRICE_W    = 4,
  parameter  int unsigned TOTAL_W    = 8,
  parameter  int unsigned LOW_THRESH = 2,
  localparam int unsigned IDX_W      = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 funds_load,
  input  logic [TOTAL_W-1:0]   funds_init,
  input  logic                 txn_valid,
  output logic                 txn_ready,
  input  logic                 txn_op,
  input  logic [IDX_W-1:0]     txn_item,
  input  logic [CNT_W-1:0]     txn_qty,
  input  logic [PRICE_W-1:0]   txn_uprice,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_code,
  output logic [TOTAL_W-1:0]   rsp_price,
  output logic [CNT_W-1:0]     rsp_count,
  output logic [TOTAL_W-1:0]   funds,
  output logic [NUM_ITEMS-1:0] empty_mask
`ifdef FCIMS_LOW_STOCK_EN
  ,
  output logic [NUM_ITEMS-1:0] low_mask
`endif
);

  state_t                state;
  logic                  op_q;
  logic [IDX_W-1:0]      item_q;
  logic [CNT_W-1:0]      qty_q;
  logic [CNT_W-1:0]      counts [NUM_ITEMS];

  logic                  accept;
  logic                  mul_done;
  logic [CNT_W+PRICE_W-1:0] product;

  logic                  bad_item;
  logic [TOTAL_W-1:0]    price;
  logic [CNT_W-1:0]      cur_count;
  logic [CNT_W-1:0]      new_count;
  logic [TOTAL_W-1:0]    new_funds;
  logic [CNT_W:0]        cnt_sum;
  logic [TOTAL_W:0]      funds_sum;
  logic [2:0]            verdict;

  assign txn_ready = (state == ST_IDLE) && !funds_load;
  assign accept    = txn_valid && txn_ready;

  // Multiplier captures qty/uprice straight from the request in the accept cycle
  seq_multiplier #(
    .A_W (CNT_W),
    .B_W (PRICE_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .a       (txn_qty),
    .b       (txn_uprice),
    .done    (mul_done),
    .product (product)
  );

  // Verdict and post-commit values for the transaction under check
  always_comb begin
    bad_item  = (32'(item_q) >= NUM_ITEMS);
    price     = TOTAL_W'(product);
    cur_count = bad_item ? '0 : counts[item_q];
    cnt_sum   = {1'b0, cur_count} + {1'b0, qty_q};
    funds_sum = {1'b0, funds} + {1'b0, price};
    new_count = cur_count;
    new_funds = funds;
    if (bad_item) begin
      verdict = RSP_BAD_ITEM;
    end else if (op_q == OP_SELL && qty_q > cur_count) begin
      verdict = RSP_NO_STOCK;
    end else if (op_q == OP_BUY && price > funds) begin
      verdict = RSP_NO_FUNDS;
    end else if (op_q == OP_BUY ? cnt_sum[CNT_W] : funds_sum[TOTAL_W]) begin
      verdict = RSP_OVERFLOW;
    end else begin
      verdict = RSP_OK;
      if (op_q == OP_BUY) begin
        new_count = cnt_sum[CNT_W-1:0];
        new_funds = funds - price;
      end else begin
        new_count = cur_count - qty_q;
        new_funds = funds_sum[TOTAL_W-1:0];
      end
    end
  end

  // Transaction FSM with registered state, response and inventory
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_BUY;
      item_q     <= '0;
      qty_q      <= '0;
      funds      <= '0;
      rsp_valid  <= 1'b0;
      rsp_code   <= RSP_OK;
      rsp_price  <= '0;
      rsp_count  <= '0;
      empty_mask <= '1;
`ifdef FCIMS_LOW_STOCK_EN
      low_mask   <= '1;
`endif
      for (int unsigned i = 0; i < NUM_ITEMS; i++) counts[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (funds_load) begin
            funds <= funds_init;
          end else if (accept) begin
            op_q   <= txn_op;
            item_q <= txn_item;
            qty_q  <= txn_qty;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          rsp_valid <= 1'b1;
          rsp_code  <= verdict;
          rsp_price <= price;
          rsp_count <= new_count;
          if (verdict == RSP_OK) begin
            counts[item_q]     <= new_count;
            funds              <= new_funds;
            empty_mask[item_q] <= (new_count == '0);
`ifdef FCIMS_LOW_STOCK_EN
            low_mask[item_q]   <= (new_count <= CNT_W'(LOW_THRESH));
`endif
          end
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inventory_txn_ctrl.sv
// Scoreboard bench for inventory_txn_ctrl (NUM_ITEMS=4, CNT_W=4, PRICE_W=4, TOTAL_W=8).
module tb_inventory_txn_ctrl;
  import fcims_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       funds_load;
  logic [7:0] funds_init;
  logic       txn_valid;
  logic       txn_ready;
  logic       txn_op;
  logic [1:0] txn_item;
  logic [3:0] txn_qty;
  logic [3:0] txn_uprice;
  logic       rsp_valid;
  logic [2:0] rsp_code;
  logic [7:0] rsp_price;
  logic [3:0] rsp_count;
  logic [7:0] funds;
  logic [3:0] empty_mask;
`ifdef FCIMS_LOW_STOCK_EN
  logic [3:0] low_mask;
`endif

  inventory_txn_ctrl #(
    .NUM_ITEMS  (4),
    .CNT_W      (4),
    .PRICE_W    (4),
    .TOTAL_W    (8),
    .LOW_THRESH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .funds_load (funds_load),
    .funds_init (funds_init),
    .txn_valid  (txn_valid),
    .txn_ready  (txn_ready),
    .txn_op     (txn_op),
    .txn_item   (txn_item),
    .txn_qty    (txn_qty),
    .txn_uprice (txn_uprice),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .rsp_price  (rsp_price),
    .rsp_count  (rsp_count),
    .funds      (funds),
    .empty_mask (empty_mask)
`ifdef FCIMS_LOW_STOCK_EN
    ,
    .low_mask   (low_mask)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic [7:0] price;
    logic [3:0] count;
    logic [7:0] fnd;
    logic [3:0] emp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, "_code"},    32'(rsp_code),   32'(e.code));
        chk({e.name, "_price"},   32'(rsp_price),  32'(e.price));
        chk({e.name, "_count"},   32'(rsp_count),  32'(e.count));
        chk({e.name, "_funds"},   32'(funds),      32'(e.fnd));
        chk({e.name, "_empty"},   32'(empty_mask), 32'(e.emp));
      end
    end
  end

  task automatic load(input logic [7:0] v);
    funds_load = 1'b1;
    funds_init = v;
    #1;
    chk("ready_low_during_load", 32'(txn_ready), 32'd0);
    @(posedge clk);
    #1;
    funds_load = 1'b0;
    funds_init = '0;
  endtask

  task automatic txn(input string name, input logic op, input logic [1:0] item,
                     input logic [3:0] qty, input logic [3:0] up,
                     input logic [2:0] code, input logic [7:0] price,
                     input logic [3:0] cnt, input logic [7:0] fnd, input logic [3:0] emp);
    #1;
    chk({name, "_ready"}, 32'(txn_ready), 32'd1);
    txn_valid  = 1'b1;
    txn_op     = op;
    txn_item   = item;
    txn_qty    = qty;
    txn_uprice = up;
    sb.push_back('{cyc + 6, code, price, cnt, fnd, emp, name});
    @(posedge clk);
    #1;
    // Garbage on the request bus while busy must not disturb the transaction
    txn_op     = ~op;
    txn_item   = ~item;
    txn_qty    = ~qty;
    txn_uprice = ~up;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    txn_valid = 1'b0;
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    funds_load = 1'b0;
    funds_init = '0;
    txn_valid  = 1'b0;
    txn_op     = OP_BUY;
    txn_item   = '0;
    txn_qty    = '0;
    txn_uprice = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_funds", 32'(funds), 32'd0);
    chk("rst_empty", 32'(empty_mask), 32'hF);
    chk("rst_ready", 32'(txn_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_code", 32'(rsp_code), 32'd0);

    load(8'd200);
    txn("buy2_q5",       OP_BUY,  2'd2,  4'd5,  4'd7, RSP_OK,       8'd35,  4'd5,  8'd165, 4'b1011);
    txn("sell2_q6",      OP_SELL, 2'd2,  4'd6,  4'd7, RSP_NO_STOCK, 8'd42,  4'd5,  8'd165, 4'b1011);
    txn("sell2_all",     OP_SELL, 2'd2,  4'd5,  4'd7, RSP_OK,       8'd35,  4'd0,  8'd200, 4'b1111);
    txn("buy1_nofunds",  OP_BUY,  2'd1, 4'd15, 4'd15, RSP_NO_FUNDS, 8'd225, 4'd0,  8'd200, 4'b1111);
    txn("buy1_q13",      OP_BUY,  2'd1, 4'd13, 4'd15, RSP_OK,       8'd195, 4'd13, 8'd5,   4'b1101);
    txn("buy1_cnt_ovf",  OP_BUY,  2'd1,  4'd3,  4'd1, RSP_OVERFLOW, 8'd3,   4'd13, 8'd5,   4'b1101);
    load(8'd250);
    txn("sell1_fnd_ovf", OP_SELL, 2'd1,  4'd1, 4'd15, RSP_OVERFLOW, 8'd15,  4'd13, 8'd250, 4'b1101);
    txn("buy0_qty0",     OP_BUY,  2'd0,  4'd0,  4'd9, RSP_OK,       8'd0,   4'd0,  8'd250, 4'b1101);
    load(8'd225);
    txn("buy3_allfunds", OP_BUY,  2'd3, 4'd15, 4'd15, RSP_OK,       8'd225, 4'd15, 8'd0,   4'b0101);
    txn("sell3_all",     OP_SELL, 2'd3, 4'd15, 4'd15, RSP_OK,       8'd225, 4'd0,  8'd225, 4'b1101);
    load(8'd240);
    txn("sell1_fnd_max", OP_SELL, 2'd1,  4'd1, 4'd15, RSP_OK,       8'd15,  4'd12, 8'd255, 4'b1101);

    // Reset during the second MUL cycle: transaction is dropped silently
    #1;
    chk("abort_ready", 32'(txn_ready), 32'd1);
    txn_valid  = 1'b1;
    txn_op     = OP_BUY;
    txn_item   = 2'd0;
    txn_qty    = 4'd7;
    txn_uprice = 4'd3;
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_funds", 32'(funds), 32'd0);
    chk("abort_empty", 32'(empty_mask), 32'hF);
    chk("abort_rsp_price", 32'(rsp_price), 32'd0);
    chk("abort_rsp_count", 32'(rsp_count), 32'd0);
    chk("abort_ready_after", 32'(txn_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    load(8'd10);
    txn("post_abort_buy", OP_BUY, 2'd0, 4'd2, 4'd3, RSP_OK, 8'd6, 4'd2, 8'd4, 4'b1110);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
